// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: counters, framebuffer addressing, sync/de/sof and pixel output.
// Latency: 3 pclk from counter state to prgb/de/hs/vs/sof; paddr leads the outputs by 2 pclk.
// Backpressure: none; free-running raster, the framebuffer must answer one cycle after paddr.
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module vga_scan_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BP        = 64,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 23,
    parameter int SYNC_POL    = 1,
    parameter int SCALE_SHIFT = 0,
    parameter int AW          = 19
) (
    input  logic          pclk,
    input  logic          rstn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    input  logic [11:0]   pdata,
    output logic [AW-1:0] paddr,
    output logic [11:0]   prgb,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] H_ACT_M1 = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_MASK   = 12'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] LINE_STEP = AW'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic        SP       = (SYNC_POL != 0);

    // Framebuffer footprint after scaling; must fit in the address space.
    localparam longint PIX = (longint'(H_ACTIVE) * longint'(V_ACTIVE)) >> (2 * SCALE_SHIFT);

    if (((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) ||
        ((V_ACTIVE % (1 << SCALE_SHIFT)) != 0) ||
        (PIX > (longint'(1) << AW))) begin : g_bad_cfg
        $error("vga_scan_gen: active area not a multiple of the scale or framebuffer exceeds 2^AW");
    end

    // Stage 0: raster counters
    logic [11:0]   hcnt;
    logic [11:0]   vcnt;
    logic [AW-1:0] line_base;

    logic act0, hs0, vs0, sof0, line_end, frame_end;

    assign act0      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs0       = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign vs0       = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    assign sof0      = (hcnt == 12'd0) && (vcnt == 12'd0);
    assign line_end  = (hcnt == H_ACT_M1) && (vcnt < V_ACT);
    assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

    // Horizontal/vertical counters; vertical steps only on horizontal wrap
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // Line base address: steps once per 2^SCALE_SHIFT active lines, cleared at frame end
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            line_base <= '0;
        end else if (frame_end) begin
            line_base <= '0;
        end else if (line_end && ((vcnt & V_MASK) == V_MASK)) begin
            line_base <= line_base + LINE_STEP;
        end
    end

    // Stage 1: framebuffer address (held through blanking) and control flags
    logic de1, hs1, vs1, sof1;

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            paddr <= '0;
            de1   <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            sof1  <= 1'b0;
        end else begin
            if (act0) begin
                paddr <= line_base + AW'(hcnt >> SCALE_SHIFT);
            end
            de1  <= act0;
            hs1  <= hs0;
            vs1  <= vs0;
            sof1 <= sof0;
        end
    end

    // Stage 2: flags wait for the framebuffer read to return
    logic de2, hs2, vs2, sof2;

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            de2  <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            sof2 <= 1'b0;
        end else begin
            de2  <= de1;
            hs2  <= hs1;
            vs2  <= vs1;
            sof2 <= sof1;
        end
    end

    // Pixel source for stage 3: framebuffer data or the optional test pattern
    logic [11:0] pix2;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] bar0;
    logic [11:0] bar_rgb0;
    logic [11:0] pat1, pat2;
    logic        sel1, sel2;

    assign bar0 = hcnt / BAR_W;

    // Bar colour lookup, left to right
    always_comb begin
        bar_rgb0 = 12'h000;
        case (bar0)
            12'd0:   bar_rgb0 = 12'hFFF;
            12'd1:   bar_rgb0 = 12'hFF0;
            12'd2:   bar_rgb0 = 12'h0FF;
            12'd3:   bar_rgb0 = 12'h0F0;
            12'd4:   bar_rgb0 = 12'hF0F;
            12'd5:   bar_rgb0 = 12'hF00;
            12'd6:   bar_rgb0 = 12'h00F;
            default: bar_rgb0 = 12'h000;
        endcase
    end

    // Pattern colour and select travel alongside the address pipeline
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            pat1 <= '0;
            pat2 <= '0;
            sel1 <= 1'b0;
            sel2 <= 1'b0;
        end else begin
            pat1 <= bar_rgb0;
            pat2 <= pat1;
            sel1 <= pattern_sel;
            sel2 <= sel1;
        end
    end

    assign pix2 = sel2 ? pat2 : pdata;
`else
    assign pix2 = pdata;
`endif

    // Stage 3: registered outputs, colour blanked outside the visible area
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            prgb <= '0;
            de   <= 1'b0;
            hs   <= ~SP;
            vs   <= ~SP;
            sof  <= 1'b0;
        end else begin
            prgb <= de2 ? pix2 : 12'h000;
            de   <= de2;
            hs   <= hs2 ? SP : ~SP;
            vs   <= vs2 ? SP : ~SP;
            sof  <= sof2;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: two small-raster instances (unscaled/active-high, 2x scaled/active-low).
// Latency: expected outputs are queued per clock edge and checked at the following falling edge.
// Backpressure: none; a registered framebuffer model answers paddr one cycle later.
module tb_vga_scan_gen;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int AWT = 8;

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct packed {
        logic [AWT-1:0] addr;
        logic [11:0]    rgb;
        logic           de;
        logic           hs;
        logic           vs;
        logic           sof;
    } obs_t;

    logic           pclk = 1'b0;
    logic           rstn = 1'b0;
    logic           pattern_sel = 1'b0;
    logic [11:0]    pdata0 = '0, pdata1 = '0;
    logic [AWT-1:0] paddr0, paddr1;
    logic [11:0]    prgb0, prgb1;
    logic           hs0, vs0, de0, sof0;
    logic           hs1, vs1, de1, sof1;

    logic [11:0]    mem [256];
    obs_t           q0 [$];
    obs_t           q1 [$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             cyc = 0;

    always #5 pclk = ~pclk;

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1), .SCALE_SHIFT(0), .AW(AWT)
    ) u_dut0 (
        .pclk(pclk), .rstn(rstn),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .pdata(pdata0), .paddr(paddr0), .prgb(prgb0),
        .hs(hs0), .vs(vs0), .de(de0), .sof(sof0)
    );

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(0), .SCALE_SHIFT(1), .AW(AWT)
    ) u_dut1 (
        .pclk(pclk), .rstn(rstn),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .pdata(pdata1), .paddr(paddr1), .prgb(prgb1),
        .hs(hs1), .vs(vs1), .de(de1), .sof(sof1)
    );

    // Raster position m cycles after the first post-reset counter state
    function automatic bit is_active(int m);
        int h = m % HT;
        int v = (m / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    // Framebuffer address of a visible raster position for a given scale
    function automatic int pix_addr(int m, int s);
        int h = m % HT;
        int v = (m / HT) % VT;
        return (v >> s) * (HA >> s) + (h >> s);
    endfunction

    // Expected outputs after an edge: n counter steps since reset, held = expected paddr
    function automatic obs_t expect_out(int n, bit in_rst, int s, bit pol,
                                        logic [AWT-1:0] held, logic psel);
        obs_t o;
        int   m, h, v;
        o.addr = held;
        o.rgb  = 12'h000;
        o.de   = 1'b0;
        o.hs   = ~pol;
        o.vs   = ~pol;
        o.sof  = 1'b0;
        if (!in_rst && n >= 3) begin
            m = n - 3;
            h = m % HT;
            v = (m / HT) % VT;
            o.de  = is_active(m);
            if (o.de)
                o.rgb = psel ? BARS[h / (HA / 8)] : mem[pix_addr(m, s)];
            o.hs  = (h >= HA + HF && h < HA + HF + HSW) ? pol : ~pol;
            o.vs  = (v >= VA + VF && v < VA + VF + VSW) ? pol : ~pol;
            o.sof = (m % (HT * VT)) == 0;
        end
        return o;
    endfunction

    // Registered framebuffer model: data for an address appears one cycle later
    initial begin
        logic [AWT-1:0] a0 = '0, a1 = '0;
        forever begin
            @(posedge pclk);
            #1;
            pdata0 = mem[a0];
            pdata1 = mem[a1];
            a0 = paddr0;
            a1 = paddr1;
        end
    end

    // Reference model: push the expected response for every clock edge
    initial begin
        int             n = 0;
        logic [AWT-1:0] held [2] = '{default: '0};
        forever begin
            @(posedge pclk);
            if (!rstn) n = 0;
            else       n = n + 1;
            for (int d = 0; d < 2; d++) begin
                if (!rstn)
                    held[d] = '0;
                else if (n >= 1 && is_active(n - 1))
                    held[d] = AWT'(pix_addr(n - 1, d));
            end
            q0.push_back(expect_out(n, !rstn, 0, 1'b1, held[0], pattern_sel));
            q1.push_back(expect_out(n, !rstn, 1, 1'b0, held[1], pattern_sel));
        end
    end

    task automatic check(string name, obs_t got, obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got addr=%0d rgb=%h de=%b hs=%b vs=%b sof=%b, want addr=%0d rgb=%h de=%b hs=%b vs=%b sof=%b",
                     name, cyc, got.addr, got.rgb, got.de, got.hs, got.vs, got.sof,
                     exp.addr, exp.rgb, exp.de, exp.hs, exp.vs, exp.sof);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle and compared against the queued expectation
    initial begin
        forever begin
            @(negedge pclk);
            cyc++;
            if (q0.size() > 0) check("dut0", {paddr0, prgb0, de0, hs0, vs0, sof0}, q0.pop_front());
            if (q1.size() > 0) check("dut1", {paddr1, prgb1, de1, hs1, vs1, sof1}, q1.pop_front());
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    endtask

    // Stimulus: reset phases at random points, fresh framebuffer contents each phase
    initial begin
        fill_mem();
        rstn = 1'b0;
        for (int ph = 0; ph < 5; ph++) begin
            rstn = 1'b0;
            @(negedge pclk);
            fill_mem();
`ifdef VGA_TEST_PATTERN_EN
            pattern_sel = (ph == 2 || ph == 4);
`endif
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            rstn = 1'b1;
            if (ph == 0)
                repeat (2 * HT * VT + 30) @(negedge pclk);
            else
                repeat ($urandom_range(HT * 3, HT * VT + HT * 6)) @(negedge pclk);
        end
        rstn = 1'b0;
        repeat (3) @(negedge pclk);
        rstn = 1'b1;
        repeat (HT * VT + 10) @(negedge pclk);
        @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
